// File: rtl/iobus_write_buffer_pkg.sv
// Shared types and constants for the IO bus write buffer: drain FSM encoding
// and the width of one buffered write entry {address, byte enables, data}.
package iobus_write_buffer_pkg;

    localparam int DATA_W         = 32;
    localparam int BE_W           = 4;
    localparam int DEFAULT_ADDR_W = 25;
    localparam int ENTRY_W        = DEFAULT_ADDR_W + BE_W + DATA_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_ISSUE = 3'd1,
        W_WAIT  = 3'd2,
        R_ISSUE = 3'd3,
        R_WAIT  = 3'd4,
        R_RESP  = 3'd5
    } drainState_e;

    function automatic int entryWidth(input int addrW);
        return addrW + BE_W + DATA_W;
    endfunction

endpackage

// File: rtl/iobus_wbuf_fifo.sv
// Synchronous power-of-two FIFO holding posted writes; push is ignored when
// full, pop is ignored when empty, and the head entry is always visible.
module iobus_wbuf_fifo
    import iobus_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         pushData_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];
    assign level_o = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q] <= pushData_i;
    end

endmodule

// File: rtl/iobus_write_buffer.sv
// Posted-write buffer between the MCS IO bus and a slower downstream bus.
// Writes are acknowledged as soon as they are queued; reads wait for the queue to drain.
module iobus_write_buffer
    import iobus_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 25
) (
    input  logic                    io_clk,
    input  logic                    io_rst_n,
    input  logic                    io_addr_strobe,
    input  logic                    io_read_strobe,
    input  logic                    io_write_strobe,
    input  logic [31:0]             io_address,
    input  logic [3:0]              io_byte_enable,
    input  logic [31:0]             io_write_data,
    output logic [31:0]             io_read_data,
    output logic                    io_ready,
    output logic                    m_addr_strobe,
    output logic                    m_read_strobe,
    output logic                    m_write_strobe,
    output logic [ADDR_W-1:0]       m_address,
    output logic [3:0]              m_byte_enable,
    output logic [31:0]             m_write_data,
    input  logic [31:0]             m_read_data,
    input  logic                    m_ready,
    output logic [$clog2(DEPTH):0]  wbuf_level
);

    localparam int EntryW = entryWidth(ADDR_W);

    drainState_e        state_q, state_d;
    logic               busy_q, pendWrite_q, pendRead_q, wAck_q;
    logic [ADDR_W-1:0]  pendAddr_q, mAddr_q;
    logic [3:0]         pendBe_q, mBe_q;
    logic [31:0]        pendData_q, mData_q, rdData_q;
    logic               accept, acceptWrite, acceptRead;
    logic               push, pop, fifoFull, fifoEmpty, startWrite, startRead;
    logic [EntryW-1:0]  pushEntry, headEntry;
    logic               unusedAddrBits;

    assign unusedAddrBits = ^io_address[31:ADDR_W];

    // A new request may start in the same cycle the previous one completes.
    assign accept      = io_addr_strobe && (!busy_q || io_ready) && (io_read_strobe || io_write_strobe);
    assign acceptWrite = accept && io_write_strobe;
    assign acceptRead  = accept && io_read_strobe && !io_write_strobe;

    assign push      = (acceptWrite || pendWrite_q) && !fifoFull;
    assign pushEntry = pendWrite_q ? {pendAddr_q, pendBe_q, pendData_q}
                                   : {io_address[ADDR_W-1:0], io_byte_enable, io_write_data};
    assign pop        = (state_q == W_WAIT) && m_ready;
    assign startWrite = (state_q == IDLE) && !fifoEmpty;
    assign startRead  = (state_q == IDLE) && fifoEmpty && pendRead_q;

    iobus_wbuf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk_i      (io_clk),
        .rst_ni     (io_rst_n),
        .push_i     (push),
        .pushData_i (pushEntry),
        .pop_i      (pop),
        .head_o     (headEntry),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .level_o    (wbuf_level)
    );

    always_ff @(posedge io_clk) begin
        if (!io_rst_n) begin
            busy_q      <= 1'b0;
            pendWrite_q <= 1'b0;
            pendRead_q  <= 1'b0;
            wAck_q      <= 1'b0;
            pendAddr_q  <= '0;
            pendBe_q    <= '0;
            pendData_q  <= '0;
        end else begin
            wAck_q <= push;
            if (accept) begin
                busy_q     <= 1'b1;
                pendAddr_q <= io_address[ADDR_W-1:0];
                pendBe_q   <= io_byte_enable;
                pendData_q <= io_write_data;
            end else if (io_ready) begin
                busy_q <= 1'b0;
            end
            if (acceptWrite && fifoFull) pendWrite_q <= 1'b1;
            else if (push)               pendWrite_q <= 1'b0;
            if (acceptRead)              pendRead_q <= 1'b1;
            else if (startRead)          pendRead_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty)      state_d = W_ISSUE;
                else if (pendRead_q) state_d = R_ISSUE;
            end
            W_ISSUE: state_d = W_WAIT;
            W_WAIT:  if (m_ready) state_d = IDLE;
            R_ISSUE: state_d = R_WAIT;
            R_WAIT:  if (m_ready) state_d = R_RESP;
            R_RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Downstream address/enables/data are loaded on entry to an issue state and then held.
    always_ff @(posedge io_clk) begin
        if (!io_rst_n) begin
            state_q  <= IDLE;
            mAddr_q  <= '0;
            mBe_q    <= '0;
            mData_q  <= '0;
            rdData_q <= '0;
        end else begin
            state_q <= state_d;
            if (startWrite) begin
                {mAddr_q, mBe_q, mData_q} <= headEntry;
            end else if (startRead) begin
                mAddr_q <= pendAddr_q;
                mBe_q   <= pendBe_q;
            end
            if ((state_q == R_WAIT) && m_ready) rdData_q <= m_read_data;
        end
    end

    assign m_addr_strobe  = (state_q == W_ISSUE) || (state_q == R_ISSUE);
    assign m_write_strobe = (state_q == W_ISSUE);
    assign m_read_strobe  = (state_q == R_ISSUE);
    assign m_address      = mAddr_q;
    assign m_byte_enable  = mBe_q;
    assign m_write_data   = mData_q;
    assign io_ready       = wAck_q || (state_q == R_RESP);
    assign io_read_data   = (state_q == R_RESP) ? rdData_q : 32'h0;

endmodule

// File: tb/tb_iobus_write_buffer.sv
// Directed and randomized bench for iobus_write_buffer with a downstream
// responder and a queue of expected downstream accesses in program order.
module tb_iobus_write_buffer;

    localparam int          DEPTH     = 4;
    localparam int          ADDR_W    = 25;
    localparam logic [31:0] ADDR_MASK = 32'h01FF_FFFF;

    logic              io_clk;
    logic              io_rst_n;
    logic              io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [31:0]       io_address, io_write_data, io_read_data;
    logic [3:0]        io_byte_enable;
    logic              io_ready;
    logic              m_addr_strobe, m_read_strobe, m_write_strobe;
    logic [ADDR_W-1:0] m_address;
    logic [3:0]        m_byte_enable;
    logic [31:0]       m_write_data, m_read_data;
    logic              m_ready;
    logic [2:0]        wbuf_level;

    typedef struct {
        bit          isRead;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } expTxn_t;

    expTxn_t     expQ[$];
    int          readyTicks[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    int          cycle = 0;
    int          dsCount = 0;
    int          ackCount = 0;
    int          maxLevel = 0;
    int          respDelay = 0;
    int          respCount = 0;
    bit          respPending = 0;
    bit          respIsRead = 0;
    bit          prevStrobe = 0;
    logic [31:0] nextRdData = 32'h0;
    logic [31:0] lastRdData = 32'h0;
    int          lastRdReadyTick = 0;

    iobus_write_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .io_clk          (io_clk),
        .io_rst_n        (io_rst_n),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_address      (io_address),
        .io_byte_enable  (io_byte_enable),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .m_addr_strobe   (m_addr_strobe),
        .m_read_strobe   (m_read_strobe),
        .m_write_strobe  (m_write_strobe),
        .m_address       (m_address),
        .m_byte_enable   (m_byte_enable),
        .m_write_data    (m_write_data),
        .m_read_data     (m_read_data),
        .m_ready         (m_ready),
        .wbuf_level      (wbuf_level)
    );

    initial begin
        io_clk = 1'b0;
        forever #5 io_clk = ~io_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit isWrite, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        io_addr_strobe  = 1'b1;
        io_write_strobe = isWrite;
        io_read_strobe  = !isWrite;
        io_address      = a;
        io_byte_enable  = be;
        io_write_data   = d;
    endtask

    // One clock: inputs drop after the edge, outputs are sampled on the falling edge,
    // and the downstream responder answers each strobe after respDelay idle cycles.
    task automatic tick();
        expTxn_t e;
        @(posedge io_clk);
        @(negedge io_clk);
        cycle++;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        m_ready         = 1'b0;
        if (m_addr_strobe) begin
            checkOutput("ds_strobe_single", 32'(prevStrobe), 32'h0);
            dsCount++;
            checkOutput("ds_expected_txn", 32'(expQ.size() > 0), 32'h1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("ds_is_read", 32'(m_read_strobe), 32'(e.isRead));
                checkOutput("ds_is_write", 32'(m_write_strobe), 32'(!e.isRead));
                checkOutput("ds_addr", 32'(m_address), e.addr);
                checkOutput("ds_be", 32'(m_byte_enable), 32'(e.be));
                if (!e.isRead) checkOutput("ds_wdata", m_write_data, e.data);
            end
            respPending = 1'b1;
            respCount   = respDelay;
            respIsRead  = m_read_strobe;
        end else if (respPending) begin
            if (respCount == 0) begin
                m_ready     = 1'b1;
                respPending = 1'b0;
                readyTicks.push_back(cycle);
                if (respIsRead) begin
                    m_read_data     = nextRdData;
                    lastRdData      = nextRdData;
                    lastRdReadyTick = cycle;
                end
            end else begin
                respCount--;
            end
        end
        prevStrobe = m_addr_strobe;
        if (io_ready) ackCount++;
        else          checkOutput("rdata_zero_idle", io_read_data, 32'h0);
        checkOutput("level_le_depth", 32'(wbuf_level <= 3'(DEPTH)), 32'h1);
        if (int'(wbuf_level) > maxLevel) maxLevel = int'(wbuf_level);
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                           input int injectAt, output int lat);
        bit seen = 1'b0;
        expQ.push_back('{1'b0, a & ADDR_MASK, be, d});
        applyStimulus(1'b1, a, be, d);
        lat = 0;
        while (!seen && lat < 500) begin
            tick();
            lat++;
            seen = io_ready;
            if (!seen && lat == injectAt) applyStimulus(1'b1, 32'hE000_0FF0, 4'hF, 32'hBAD0_BAD0);
        end
        checkOutput("wr_ack_seen", 32'(seen), 32'h1);
        checkOutput("wr_ack_rdata_zero", io_read_data, 32'h0);
    endtask

    task automatic doRead(input logic [31:0] a, input logic [3:0] be, output int lat);
        bit seen = 1'b0;
        expQ.push_back('{1'b1, a & ADDR_MASK, be, 32'h0});
        applyStimulus(1'b0, a, be, 32'h0);
        lat = 0;
        while (!seen && lat < 500) begin
            tick();
            lat++;
            seen = io_ready;
        end
        checkOutput("rd_ack_seen", 32'(seen), 32'h1);
        checkOutput("rd_data", io_read_data, lastRdData);
        checkOutput("rd_ack_timing", 32'(cycle), 32'(lastRdReadyTick + 1));
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while ((expQ.size() > 0 || respPending) && n < 1000) begin
            tick();
            n++;
        end
        checkOutput({tag, "_drained"}, 32'(n < 1000), 32'h1);
        repeat (3) tick();
    endtask

    initial begin
        int lat;
        int dsBase;
        int ackBase;
        logic [31:0] a, d;
        logic [3:0]  be;

        io_rst_n        = 1'b0;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_address      = 32'h0;
        io_byte_enable  = 4'h0;
        io_write_data   = 32'h0;
        m_ready         = 1'b0;
        m_read_data     = 32'h0;

        tick();
        tick();
        checkOutput("rst_level", 32'(wbuf_level), 32'h0);
        checkOutput("rst_io_ready", 32'(io_ready), 32'h0);
        checkOutput("rst_strobes", 32'({m_addr_strobe, m_read_strobe, m_write_strobe}), 32'h0);
        checkOutput("rst_rdata", io_read_data, 32'h0);
        io_rst_n = 1'b1;
        tick();

        // Single write: queued with one-cycle ack, address truncated downstream.
        respDelay = 2;
        dsBase = dsCount;
        doWrite(32'hE000_0010, 4'hF, 32'hDEAD_BEEF, 0, lat);
        checkOutput("single_wr_latency", 32'(lat), 32'h1);
        waitIdle("single_wr");
        checkOutput("single_wr_ds_count", 32'(dsCount - dsBase), 32'h1);
        checkOutput("single_wr_level", 32'(wbuf_level), 32'h0);

        // Five writes against a slow downstream: the fifth waits for a free slot.
        respDelay = 10;
        readyTicks.delete();
        maxLevel = 0;
        dsBase = dsCount;
        for (int i = 0; i < 4; i++) begin
            doWrite(32'hE000_0100 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i), 0, lat);
            checkOutput("burst_wr_latency", 32'(lat), 32'h1);
        end
        checkOutput("burst_level_full", 32'(wbuf_level), 32'(DEPTH));
        doWrite(32'hE000_0110, 4'h3, 32'hA000_0004, 0, lat);
        checkOutput("burst_fifth_ack_tick", 32'(cycle),
                    32'((readyTicks.size() > 0) ? readyTicks[0] + 2 : 0));
        waitIdle("burst");
        checkOutput("burst_level_peak", 32'(maxLevel), 32'(DEPTH));
        checkOutput("burst_ds_count", 32'(dsCount - dsBase), 32'h5);
        checkOutput("burst_level_end", 32'(wbuf_level), 32'h0);

        // Two writes then a read: writes must reach downstream first.
        respDelay = 3;
        dsBase = dsCount;
        doWrite(32'hE000_0200, 4'hF, 32'h1111_1111, 0, lat);
        doWrite(32'hE000_0204, 4'h1, 32'h2222_2222, 0, lat);
        nextRdData = 32'h1234_5678;
        doRead(32'hE000_0020, 4'hF, lat);
        checkOutput("wwr_read_value", io_read_data, 32'h1234_5678);
        waitIdle("wwr");
        checkOutput("wwr_ds_count", 32'(dsCount - dsBase), 32'h3);

        // Stray m_ready while idle.
        dsBase = dsCount;
        ackBase = ackCount;
        m_ready = 1'b1;
        tick();
        repeat (4) tick();
        checkOutput("spurious_ds_count", 32'(dsCount - dsBase), 32'h0);
        checkOutput("spurious_ack_count", 32'(ackCount - ackBase), 32'h0);
        checkOutput("spurious_level", 32'(wbuf_level), 32'h0);

        // Extra address strobe while a write is parked waiting for space.
        respDelay = 20;
        dsBase = dsCount;
        ackBase = ackCount;
        for (int i = 0; i < 4; i++) doWrite(32'hE000_0300 + 32'(i * 4), 4'hF, 32'hC000_0000 + 32'(i), 0, lat);
        doWrite(32'hE000_0310, 4'hF, 32'hC000_0004, 3, lat);
        waitIdle("extra_strobe");
        checkOutput("extra_strobe_ds_count", 32'(dsCount - dsBase), 32'h5);
        checkOutput("extra_strobe_ack_count", 32'(ackCount - ackBase), 32'h5);

        // Reset while the drain waits for m_ready with three entries queued.
        respDelay = 40;
        for (int i = 0; i < 3; i++) doWrite(32'hE000_0400 + 32'(i * 4), 4'hF, 32'hD000_0000 + 32'(i), 0, lat);
        repeat (2) tick();
        checkOutput("midrst_level_before", 32'(wbuf_level), 32'h3);
        io_rst_n = 1'b0;
        tick();
        checkOutput("midrst_level", 32'(wbuf_level), 32'h0);
        checkOutput("midrst_io_ready", 32'(io_ready), 32'h0);
        checkOutput("midrst_strobe", 32'(m_addr_strobe), 32'h0);
        io_rst_n = 1'b1;
        expQ.delete();
        respPending = 1'b0;
        dsBase = dsCount;
        ackBase = ackCount;
        m_ready = 1'b1;
        tick();
        repeat (10) tick();
        checkOutput("midrst_ds_after", 32'(dsCount - dsBase), 32'h0);
        checkOutput("midrst_ack_after", 32'(ackCount - ackBase), 32'h0);
        checkOutput("midrst_level_after", 32'(wbuf_level), 32'h0);

        // Randomized mix of reads and writes with varying downstream latency.
        for (int k = 0; k < 60; k++) begin
            respDelay = int'($urandom_range(0, 6));
            a  = $urandom;
            be = 4'($urandom);
            d  = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                doWrite(a, be, d, 0, lat);
            end else begin
                nextRdData = $urandom;
                doRead(a, be, lat);
            end
        end
        waitIdle("rand");
        checkOutput("rand_queue_empty", 32'(expQ.size()), 32'h0);
        checkOutput("rand_level", 32'(wbuf_level), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
